fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_hold_buffer.sv | 72 +++++++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared configuration for the instruction fetch stage: word width,
// instruction size, the bubble instruction and the FSM state encodings.
package fetch_stage_pkg;

    localparam int                  WORD_LEN    = 32;
    localparam int                  INSTR_BYTES = 4;
    localparam logic [WORD_LEN-1:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// IF/ID slot plus a one-entry hold buffer that parks a response which
// arrives while decode is stalled on an already-occupied slot.
module fetch_hold_buffer #(
    parameter int                  WORD_LEN  = fetch_stage_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_stall,
    input  logic                i_load_slot,
    input  logic                i_load_hold,
    input  logic                i_move_hold,
    input  logic [WORD_LEN-1:0] i_data,
    input  logic [WORD_LEN-1:0] i_pc,
    output logic                o_valid,
    output logic [WORD_LEN-1:0] o_instr,
    output logic [WORD_LEN-1:0] o_pc
);

    logic                r_hold_instr_valid;
    logic [WORD_LEN-1:0] r_hold_instr;
    logic [WORD_LEN-1:0] r_hold_pc;
    logic                r_valid;
    logic [WORD_LEN-1:0] r_instr;
    logic [WORD_LEN-1:0] r_pc;

    // Hold buffer: captures a parked response, dropped on a redirect or once moved.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_instr_valid <= 1'b0;
            r_hold_instr       <= '0;
            r_hold_pc          <= '0;
        end else if (i_flush) begin
            r_hold_instr_valid <= 1'b0;
        end else if (i_load_hold) begin
            r_hold_instr_valid <= 1'b1;
            r_hold_instr       <= i_data;
            r_hold_pc          <= i_pc;
        end else if (i_move_hold) begin
            r_hold_instr_valid <= 1'b0;
        end
    end

    // IF/ID slot: flush beats load, a stalled valid slot holds, otherwise it drains.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load_slot) begin
            r_valid <= 1'b1;
            r_instr <= i_data;
            r_pc    <= i_pc;
        end else if (i_move_hold && r_hold_instr_valid) begin
            r_valid <= 1'b1;
            r_instr <= r_hold_instr;
            r_pc    <= r_hold_pc;
        end else if (!(i_stall && r_valid)) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_valid ? r_instr : NOP_INSTR;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory, advances the program counter on each accepted request, handles
// redirects from execute and stops permanently on a misaligned PC.
module fetch_stage #(
    parameter int                  WORD_LEN  = fetch_stage_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_LEN-1:0] pc,
    output logic                pc_enable,
    output logic [WORD_LEN-1:0] pc_next,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    input  logic                stall,
    output logic                imem_req_valid,
    output logic [WORD_LEN-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [WORD_LEN-1:0] imem_resp_data,
    output logic                ifid_valid,
    output logic [WORD_LEN-1:0] ifid_instr,
    output logic [WORD_LEN-1:0] ifid_pc,
    output logic                fetch_fault
);

    import fetch_stage_pkg::fetch_state_t;
    import fetch_stage_pkg::IDLE;
    import fetch_stage_pkg::REQ;
    import fetch_stage_pkg::WAIT;
    import fetch_stage_pkg::HOLD;
    import fetch_stage_pkg::FAULT;
    import fetch_stage_pkg::INSTR_BYTES;

    localparam int ALIGN_BITS = $clog2(INSTR_BYTES);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic                r_drop;
    logic                w_drop_next;
    logic [WORD_LEN-1:0] r_req_pc;

    logic                w_aligned;
    logic                w_handshake;
    logic                w_load_slot;
    logic                w_load_hold;
    logic                w_move_hold;
    logic                w_req_valid;
    logic [WORD_LEN-1:0] w_req_addr;
    logic                w_pc_enable;
    logic [WORD_LEN-1:0] w_pc_next;
    logic                w_ifid_valid;

    assign w_aligned   = (pc[ALIGN_BITS-1:0] == '0);
    assign w_handshake = (r_state == REQ) && w_aligned && imem_req_ready;

    // State, drop flag and the address of the request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_drop   <= 1'b0;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
            if (w_handshake) begin
                r_req_pc <= pc;
            end
        end
    end

    // Next state, memory request, PC update and slot control; a redirect overrides all.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_load_slot  = 1'b0;
        w_load_hold  = 1'b0;
        w_move_hold  = 1'b0;
        w_req_valid  = 1'b0;
        w_req_addr   = '0;
        w_pc_enable  = 1'b0;
        w_pc_next    = '0;

        case (r_state)
            IDLE: begin
                w_state_next = REQ;
            end
            REQ: begin
                if (!w_aligned) begin
                    // A redirect rescues a bad PC before it is ever requested.
                    if (!branch_taken) begin
                        w_state_next = FAULT;
                    end
                end else begin
                    w_req_valid = 1'b1;
                    w_req_addr  = pc;
                    if (imem_req_ready) begin
                        w_pc_enable  = 1'b1;
                        w_pc_next    = pc + WORD_LEN'(INSTR_BYTES);
                        w_state_next = WAIT;
                        // Request accepted on the wrong path: fetch it, then throw it away.
                        w_drop_next  = branch_taken;
                    end
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    w_state_next = REQ;
                    w_drop_next  = 1'b0;
                    if (!r_drop && !branch_taken) begin
                        if (!w_ifid_valid || !stall) begin
                            w_load_slot = 1'b1;
                        end else begin
                            w_load_hold  = 1'b1;
                            w_state_next = HOLD;
                        end
                    end
                end else if (branch_taken) begin
                    w_drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_state_next = REQ;
                end else if (!stall) begin
                    w_move_hold  = 1'b1;
                    w_state_next = REQ;
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (branch_taken) begin
            w_pc_enable = 1'b1;
            w_pc_next   = branch_target;
        end
    end

    fetch_hold_buffer #(
        .WORD_LEN  (WORD_LEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_hold_buffer (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_flush     (branch_taken),
        .i_stall     (stall),
        .i_load_slot (w_load_slot),
        .i_load_hold (w_load_hold),
        .i_move_hold (w_move_hold),
        .i_data      (imem_resp_data),
        .i_pc        (r_req_pc),
        .o_valid     (w_ifid_valid),
        .o_instr     (ifid_instr),
        .o_pc        (ifid_pc)
    );

    // Combinational outputs are forced to zero while reset is held.
    assign pc_enable      = reset & w_pc_enable;
    assign pc_next        = reset ? w_pc_next : '0;
    assign imem_req_valid = reset & w_req_valid;
    assign imem_req_addr  = reset ? w_req_addr : '0;
    assign ifid_valid     = w_ifid_valid;
    assign fetch_fault    = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int            W   = 32;
    localparam logic [W-1:0]  NOP = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] pc = '0;
    logic         pc_enable;
    logic [W-1:0] pc_next;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic         stall = 1'b0;
    logic         imem_req_valid;
    logic [W-1:0] imem_req_addr;
    logic         imem_req_ready = 1'b0;
    logic         imem_resp_valid = 1'b0;
    logic [W-1:0] imem_resp_data = '0;
    logic         ifid_valid;
    logic [W-1:0] ifid_instr;
    logic [W-1:0] ifid_pc;
    logic         fetch_fault;

    fetch_stage #(.WORD_LEN(W), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_enable      (pc_enable),
        .pc_next        (pc_next),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_consumed = 0;

    // Reference program: the instruction at every address, and the stream
    // decode should see (sequential from the last reset or redirect).
    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } exp_t;
    exp_t         exp_q[$];
    logic [W-1:0] exp_ptr = '0;

    // Environment: program counter register and a single-slot memory.
    logic [W-1:0] pc_r = '0;
    bit           pend = 1'b0;
    bit           resp_real = 1'b0;
    int           pend_lat = 0;
    logic [W-1:0] pend_addr = '0;
    int p_ready = 100, p_stall = 0, p_branch = 0, p_spur = 0, min_lat = 1, max_lat = 1;
    bit prev_br = 1'b0;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: exp_ptr, instr: mem_word(exp_ptr)});
            exp_ptr = exp_ptr + W'(4);
        end
    endfunction

    function automatic void restart(input logic [W-1:0] a);
        exp_q.delete();
        exp_ptr = a;
        refill();
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol rules every cycle, scoreboard on each instruction decode takes.
    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] nx;
        if (reset) begin
            if (!ifid_valid) check("nop_when_empty", ifid_instr, NOP);
            if (prev_br) check("flush_after_branch", W'(ifid_valid), W'(0));
            if (imem_req_valid) begin
                check("one_outstanding", W'(pend || resp_real), W'(0));
                check("req_aligned", W'(imem_req_addr[1:0]), W'(0));
            end
            if (branch_taken) begin
                check("branch_pc_enable", W'(pc_enable), W'(1));
                check("branch_pc_next", pc_next, branch_target);
                restart(branch_target);
            end else if (imem_req_valid && imem_req_ready) begin
                nx = imem_req_addr + W'(4);
                check("hs_pc_enable", W'(pc_enable), W'(1));
                check("hs_pc_next", pc_next, nx);
            end else begin
                check("idle_pc_enable", W'(pc_enable), W'(0));
            end
            if (ifid_valid && !stall && !branch_taken) begin
                e = exp_q.pop_front();
                refill();
                n_consumed++;
                $display("[TB] deliver pc=%h instr=%h", ifid_pc, ifid_instr);
                check("ifid_pc", ifid_pc, e.pc);
                check("ifid_instr", ifid_instr, e.instr);
            end
            prev_br = branch_taken;
        end else begin
            prev_br = 1'b0;
        end
    end

    // Driver: sample at the falling edge, update environment just after the rising edge.
    task automatic run_cycles(input int n);
        bit           hs;
        bit           en;
        logic [W-1:0] nx;
        logic [W-1:0] ad;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            ad = imem_req_addr;
            en = pc_enable;
            nx = pc_next;
            @(posedge clk);
            #1;
            if (en) pc_r = nx;
            pc = pc_r;
            imem_resp_valid = 1'b0;
            resp_real = 1'b0;
            if (hs) begin
                pend = 1'b1;
                pend_addr = ad;
                pend_lat = $urandom_range(min_lat, max_lat);
            end
            if (pend) begin
                if (pend_lat <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = mem_word(pend_addr);
                    resp_real = 1'b1;
                    pend = 1'b0;
                end else begin
                    pend_lat--;
                end
            end else begin
                imem_resp_data = $urandom();
                imem_resp_valid = ($urandom_range(0, 99) < p_spur);
            end
            imem_req_ready = ($urandom_range(0, 99) < p_ready);
            stall = ($urandom_range(0, 99) < p_stall);
            branch_taken = ($urandom_range(0, 99) < p_branch);
            branch_target = W'($urandom_range(0, 1023)) << 2;
        end
    endtask

    // Asynchronous reset mid-cycle, reset-value checks, then one IDLE cycle before REQ.
    task automatic do_reset(input logic [W-1:0] start_pc);
        logic [W-1:0] exp_addr;
        #2;
        reset = 1'b0;
        pend = 1'b0;
        resp_real = 1'b0;
        imem_resp_valid = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0ABC;
        imem_req_ready = 1'b1;
        #1;
        check("rst_pc_enable", W'(pc_enable), W'(0));
        check("rst_pc_next", pc_next, '0);
        check("rst_req_valid", W'(imem_req_valid), W'(0));
        check("rst_req_addr", imem_req_addr, '0);
        check("rst_ifid_valid", W'(ifid_valid), W'(0));
        check("rst_ifid_instr", ifid_instr, NOP);
        check("rst_ifid_pc", ifid_pc, '0);
        check("rst_fetch_fault", W'(fetch_fault), W'(0));
        branch_taken = 1'b0;
        imem_req_ready = 1'b0;
        stall = 1'b0;
        pc_r = start_pc;
        pc = pc_r;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        restart(start_pc);
        @(negedge clk);
        check("idle_no_req", W'(imem_req_valid), W'(0));
        @(negedge clk);
        exp_addr = (start_pc[1:0] == 2'b00) ? start_pc : '0;
        check("first_req_valid", W'(imem_req_valid), W'(start_pc[1:0] == 2'b00));
        check("first_req_addr", imem_req_addr, exp_addr);
        $display("[TB] reset released, start pc=%h", start_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        // Straight-line fetch from 0 with a 1-cycle memory.
        do_reset('0);
        p_ready = 100; p_stall = 0; p_branch = 0; p_spur = 0; min_lat = 1; max_lat = 1;
        base = n_consumed;
        run_cycles(12);
        check("straight_count", W'(n_consumed - base >= 3), W'(1));

        // Back-pressure: two responses while decode stalls.
        do_reset(32'h40);
        p_stall = 100;
        run_cycles(8);
        #1;
        check("bp_no_req", W'(imem_req_valid), W'(0));
        check("bp_slot_valid", W'(ifid_valid), W'(1));
        check("bp_slot_pc", ifid_pc, 32'h40);
        check("bp_slot_instr", ifid_instr, mem_word(32'h40));
        p_stall = 0;
        base = n_consumed;
        run_cycles(10);
        check("bp_count", W'(n_consumed - base >= 2), W'(1));

        // Redirect while the request for 0x8 is outstanding.
        do_reset('0);
        min_lat = 2; max_lat = 2;
        k = 0;
        while (!(pend && pend_addr == 32'h8) && k < 40) begin
            run_cycles(1);
            k++;
        end
        check("redirect_setup", W'(pend && pend_addr == 32'h8), W'(1));
        branch_taken = 1'b1;
        branch_target = 32'h100;
        base = n_consumed;
        run_cycles(10);
        check("redirect_count", W'(n_consumed - base >= 1), W'(1));

        // Redirect and stall together while the slot is occupied.
        k = 0;
        while (!ifid_valid && k < 20) begin
            run_cycles(1);
            k++;
        end
        check("redir_stall_setup", W'(ifid_valid), W'(1));
        branch_taken = 1'b1;
        stall = 1'b1;
        branch_target = 32'h200;
        #1;
        check("redir_stall_pc_next", pc_next, 32'h200);
        run_cycles(10);

        // Randomized traffic.
        do_reset('0);
        p_ready = 70; p_stall = 30; p_branch = 5; p_spur = 10; min_lat = 1; max_lat = 3;
        base = n_consumed;
        run_cycles(3000);
        check("random_count", W'(n_consumed - base >= 100), W'(1));

        // Reset in the middle of an outstanding request.
        p_branch = 0; p_spur = 0; p_stall = 0; p_ready = 100; min_lat = 3; max_lat = 3;
        k = 0;
        while (!pend && k < 50) begin
            run_cycles(1);
            k++;
        end
        check("midwait_setup", W'(pend), W'(1));
        do_reset(pc_r);
        run_cycles(10);

        // PC wrap-around.
        do_reset(32'hFFFF_FFFC);
        min_lat = 1; max_lat = 1;
        run_cycles(1);
        #1;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_pc_enable", W'(pc_enable), W'(1));
        check("wrap_pc_next", pc_next, '0);
        run_cycles(8);

        // Misaligned PC: no request, sticky fault until reset.
        do_reset(32'h2);
        run_cycles(5);
        #1;
        check("mis_fault", W'(fetch_fault), W'(1));
        check("mis_no_req", W'(imem_req_valid), W'(0));
        run_cycles(5);
        #1;
        check("mis_fault_sticky", W'(fetch_fault), W'(1));
        do_reset('0);
        #1;
        check("mis_fault_cleared", W'(fetch_fault), W'(0));
        run_cycles(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
